// File: rtl/clock_enable_scheduler.sv
// Registered clock-enable generator for the clock-gating stage.
// Optional macro CLOCK_EN_BURST_CNT_EN adds o_burst_cnt (completed ON windows).
module clock_enable_scheduler #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_repeat,
    input  logic [CNT_WIDTH-1:0] i_on_cycles,
    input  logic [CNT_WIDTH-1:0] i_off_cycles,
    output logic                 o_clock_en,
    output logic                 o_busy,
`ifdef CLOCK_EN_BURST_CNT_EN
    output logic [7:0]           o_burst_cnt,
`endif
    output logic                 o_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] on_len;
    logic [CNT_WIDTH-1:0] off_len;
    logic                 rep;

    assign o_busy = (state != S_IDLE);

    // Main FSM: the enable and done pulse are registered alongside the state.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            on_len     <= '0;
            off_len    <= '0;
            rep        <= 1'b0;
            o_clock_en <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start && !i_stop) begin
                        on_len  <= i_on_cycles;
                        off_len <= i_off_cycles;
                        rep     <= i_repeat;
                        if (i_on_cycles != '0) begin
                            state      <= S_ON;
                            cnt        <= i_on_cycles - ONE;
                            o_clock_en <= 1'b1;
                        end else begin
                            o_done <= 1'b1;
                        end
                    end
                end
                S_ON: begin
                    if (i_stop) begin
                        state      <= S_IDLE;
                        o_clock_en <= 1'b0;
                        o_done     <= 1'b1;
                    end else if (cnt == '0) begin
                        if (!rep) begin
                            state      <= S_IDLE;
                            o_clock_en <= 1'b0;
                            o_done     <= 1'b1;
                        end else if (off_len != '0) begin
                            state      <= S_OFF;
                            cnt        <= off_len - ONE;
                            o_clock_en <= 1'b0;
                        end else begin
                            cnt <= on_len - ONE;
                        end
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                S_OFF: begin
                    if (i_stop) begin
                        state  <= S_IDLE;
                        o_done <= 1'b1;
                    end else if (cnt == '0) begin
                        state      <= S_ON;
                        cnt        <= on_len - ONE;
                        o_clock_en <= 1'b1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    o_clock_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLOCK_EN_BURST_CNT_EN
    logic win_done;
    logic start_ok;

    assign win_done = (state == S_ON) && !i_stop && (cnt == '0);
    assign start_ok = (state == S_IDLE) && i_start && !i_stop;

    // Saturating count of naturally completed ON windows.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_burst_cnt <= 8'd0;
        end else if (start_ok) begin
            o_burst_cnt <= 8'd0;
        end else if (win_done && (o_burst_cnt != 8'hFF)) begin
            o_burst_cnt <= o_burst_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// Directed testbench for clock_enable_scheduler.
// Burst-counter checks are compiled only with CLOCK_EN_BURST_CNT_EN.
module tb_clock_enable_scheduler;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       stop;
    logic       rep;
    logic [7:0] on_c;
    logic [7:0] off_c;
    logic       en;
    logic       busy;
    logic       done;
`ifdef CLOCK_EN_BURST_CNT_EN
    logic [7:0] burst;
`endif

    int errors = 0;
    int checks = 0;

    clock_enable_scheduler #(.CNT_WIDTH(8)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .i_stop       (stop),
        .i_repeat     (rep),
        .i_on_cycles  (on_c),
        .i_off_cycles (off_c),
        .o_clock_en   (en),
        .o_busy       (busy),
`ifdef CLOCK_EN_BURST_CNT_EN
        .o_burst_cnt  (burst),
`endif
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [7:0] on, input logic [7:0] off,
                        input logic r);
        on_c  = on;
        off_c = off;
        rep   = r;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Samples en/done n times, one tick apart, starting now.
    task automatic run_count(input int n, output int hi, output int dn,
                             output int dn_idx);
        hi = 0;
        dn = 0;
        dn_idx = -1;
        for (int i = 0; i < n; i++) begin
            if (en) hi++;
            if (done) begin
                dn++;
                if (dn_idx < 0) dn_idx = i;
            end
            tick();
        end
    endtask

    initial begin
        int hi;
        int dn;
        int di;
        logic [19:0] pat;
        logic [19:0] exp_pat;

        rstn  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        rep   = 1'b0;
        on_c  = 8'd0;
        off_c = 8'd0;
        #1;
        chk("rst_en", {31'd0, en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Single window of 10 cycles.
        kick(8'd10, 8'd0, 1'b0);
        run_count(15, hi, dn, di);
        chk("single_hi", hi, 32'd10);
        chk("single_done_n", dn, 32'd1);
        chk("single_done_at", di, 32'd10);
        chk("single_busy", {31'd0, busy}, 32'd0);

        // Periodic on=3 off=2.
        kick(8'd3, 8'd2, 1'b1);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            pat[i] = en;
            exp_pat[i] = ((i % 5) < 3);
            if (done) dn++;
            if (i < 19) tick();
        end
        chk("periodic_pat", {12'd0, pat}, {12'd0, exp_pat});
        chk("periodic_nodone", dn, 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("periodic_stop_en", {31'd0, en}, 32'd0);
        chk("periodic_stop_done", {31'd0, done}, 32'd1);
        chk("periodic_stop_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("periodic_done_1cyc", {31'd0, done}, 32'd0);

        // on=0: immediate done, no enable.
        kick(8'd0, 8'd3, 1'b0);
        chk("zero_en", {31'd0, en}, 32'd0);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        chk("zero_done", {31'd0, done}, 32'd1);
        tick();
        chk("zero_done_1cyc", {31'd0, done}, 32'd0);

        // on=4 off=0 repeat: continuously high until stop.
        kick(8'd4, 8'd0, 1'b1);
        run_count(30, hi, dn, di);
        chk("cont_hi", hi, 32'd30);
        chk("cont_nodone", dn, 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("cont_stop_en", {31'd0, en}, 32'd0);
        chk("cont_stop_done", {31'd0, done}, 32'd1);
        tick();

        // Maximum window.
        kick(8'd255, 8'd0, 1'b0);
        run_count(300, hi, dn, di);
        chk("max_hi", hi, 32'd255);
        chk("max_done_n", dn, 32'd1);
        chk("max_done_at", di, 32'd255);

        // start+stop together in IDLE.
        stop = 1'b1;
        kick(8'd5, 8'd0, 1'b0);
        stop = 1'b0;
        chk("collide_busy", {31'd0, busy}, 32'd0);
        chk("collide_done", {31'd0, done}, 32'd0);
        tick();
        chk("collide_done2", {31'd0, done}, 32'd0);

        // Stop in IDLE alone: no done.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("idle_stop_done", {31'd0, done}, 32'd0);

        // Start while busy is ignored.
        kick(8'd5, 8'd0, 1'b0);
        hi = en ? 1 : 0;
        kick(8'd20, 8'd0, 1'b1);
        begin
            int h2;
            run_count(30, h2, dn, di);
            hi += h2;
        end
        chk("busy_start_hi", hi, 32'd5);
        chk("busy_start_done", dn, 32'd1);

        // Asynchronous reset mid-ON.
        kick(8'd10, 8'd0, 1'b0);
        tick();
        tick();
        tick();
        chk("pre_rst_en", {31'd0, en}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_en", {31'd0, en}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("arst_idle", {31'd0, busy}, 32'd0);
        chk("arst_en2", {31'd0, en}, 32'd0);

`ifdef CLOCK_EN_BURST_CNT_EN
        chk("burst_rst", {24'd0, burst}, 32'd0);
        kick(8'd2, 8'd1, 1'b1);
        chk("burst_clr", {24'd0, burst}, 32'd0);
        for (int i = 0; i < 9; i++) tick();
        chk("burst_3", {24'd0, burst}, 32'd3);
        chk("burst_in_on", {31'd0, en}, 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("burst_abort", {24'd0, burst}, 32'd3);
        tick();
        kick(8'd2, 8'd0, 1'b0);
        chk("burst_restart", {24'd0, burst}, 32'd0);
        tick();
        tick();
        chk("burst_single", {24'd0, burst}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_enable_scheduler.md
Name: clock_enable_scheduler

Overview:
- Generates the registered clock-enable for the clock-gating stage; its o_clock_en drives that stage's i_clock_en directly.
- Produces programmable ON windows of exact cycle length. Optionally repeats them with programmable OFF gaps.
- Software or a controller starts it with a one-cycle pulse and can abort it at any time.

Parameters:
- CNT_WIDTH, 8, width of the on/off length inputs and the internal down-counter.

Ports:
- i_clk  input  1  system clock; all state updates on its rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_start  input  1  one-cycle start request; honoured only in IDLE.
- i_stop  input  1  abort request; honoured in any state.
- i_repeat  input  1  0 = single ON window, 1 = periodic ON/OFF; latched at start.
- i_on_cycles  input  CNT_WIDTH  ON window length in i_clk cycles; latched at start.
- i_off_cycles  input  CNT_WIDTH  OFF gap length in i_clk cycles; latched at start.
- o_clock_en  output  1  registered enable to the gating stage.
- o_busy  output  1  high whenever the state is not IDLE.
- o_done  output  1  one-cycle pulse when the scheduler returns to IDLE.

Behaviour:
- Reset (i_rstn low, asynchronous): state IDLE; o_clock_en=0, o_busy=0, o_done=0; counter and latched settings cleared.
- o_clock_en comes straight from a flop clocked on the rising edge of i_clk, so it never glitches and is stable through the low phase of i_clk for the downstream latch.
- States: IDLE, ON, OFF.
- IDLE:
  - i_start=1 and i_stop=0 latches i_on_cycles, i_off_cycles and i_repeat.
  - If i_on_cycles != 0: go to ON, counter = i_on_cycles-1, o_clock_en=1 from the next cycle.
  - If i_on_cycles == 0: stay in IDLE, no enable pulse, o_done pulses for one cycle.
- ON:
  - o_clock_en=1; the counter decrements each cycle.
  - When counter==0 and repeat=0: go to IDLE, o_clock_en=0, o_done=1 for one cycle.
  - When counter==0, repeat=1 and off_cycles!=0: go to OFF, counter = off_cycles-1.
  - When counter==0, repeat=1 and off_cycles==0: reload counter = on_cycles-1 and stay in ON; o_clock_en stays high continuously.
- OFF:
  - o_clock_en=0; the counter decrements each cycle.
  - When counter==0: go to ON, counter = on_cycles-1.
- Latency:
  - Start sampled at edge k gives o_clock_en high after edge k through edge k+N, i.e. exactly N=on_cycles cycles.
  - The OFF gap is exactly off_cycles cycles.
- i_stop=1 in ON or OFF: at the next edge go to IDLE, o_clock_en=0, o_done=1; a partial window is not completed.
- i_stop=1 in IDLE: no effect, and no o_done pulse.
- i_start and i_stop in the same cycle in IDLE: stop wins and start is ignored.
- i_start while busy: ignored. Input changes while busy are ignored because the settings are latched.
- o_done and i_start in the same cycle: the start is accepted, since the state is already IDLE.
- Counter arithmetic is unsigned CNT_WIDTH with no wrap. The maximum window is 2^CNT_WIDTH-1 cycles.

Optional Feature:
- Macro CLOCK_EN_BURST_CNT_EN.
- Defined:
  - Adds output o_burst_cnt (8 bits), counting ON windows that complete naturally; an aborted window is not counted.
  - Saturates at 255, clears on an accepted start, and resets to 0.
  - It increments on the ON-window-complete edge (any ON→OFF, ON→IDLE, or ON reload transition when counter==0), simultaneously with o_done where o_done occurs.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-ON (on_cycles=10, assert i_rstn=0 at cycle 4) → o_clock_en, o_busy, o_done all 0 immediately (asynchronous); IDLE after release.
- Single window (on_cycles=10, repeat=0, start at t=100ns, 10ns clock) → o_clock_en high for exactly 10 cycles; o_done pulses once on the cycle o_clock_en falls; o_busy low afterwards.
- Periodic (on=3, off=2, repeat=1) for 20 cycles → o_clock_en pattern 11100 repeated 4 times; stop at cycle 20 → o_clock_en 0 next cycle, one o_done pulse.
- Edge lengths: on=0 → no enable, one o_done; on=4, off=0, repeat=1 → o_clock_en continuously high until stop; on=255 → exactly 255 high cycles.
- Collisions: start+stop together in IDLE → remains IDLE, no o_done; start during ON with different on_cycles → ignored, original length kept.
- With CLOCK_EN_BURST_CNT_EN defined (on=2, off=1, repeat=1, stop after 3 windows plus 1 cycle) → o_burst_cnt=3; new start clears it to 0.
